// File: rtl/tns_decoder_06_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tns_decoder_06_pkg
// Description : Shared TNS link constants (codeword weights, data width) and
//               the weighted-sum helper used by the 6-bit TNS decoder.
// Revision    : 1.0  initial release
// ============================================================================
package tns_decoder_06_pkg;

    // Decoded data width.
    localparam int BLEN02 = 4;

    // Codeword width and width of the raw weighted sum.
    localparam int CW_W  = 6;
    localparam int SUM_W = 5;

    // Codeword weights, MSB (bit 5) down to bit 0.
    localparam logic [SUM_W-1:0] TNS02_A  = 5'd8;
    localparam logic [SUM_W-1:0] TNS02_B  = 5'd4;
    localparam logic [SUM_W-1:0] TNS02_C  = 5'd4;
    localparam logic [SUM_W-1:0] TNS01_A  = 5'd2;
    localparam logic [SUM_W-1:0] TNS01_B  = 5'd1;
    localparam logic [SUM_W-1:0] TNS_BIT0 = 5'd1;

    // Largest sum that still maps onto a legal data value.
    localparam logic [SUM_W-1:0] DATA_MAX = 5'd15;

    // One decoded word as carried by the output stage.
    typedef struct packed {
        logic [BLEN02-1:0] data;
        logic              illegal;
        logic              xtalk;
    } dec_word_t;

    // Weighted sum of a codeword; the maximum (20) fits in SUM_W bits.
    function automatic logic [SUM_W-1:0] tns_weight_sum(input logic [CW_W-1:0] cw);
        logic [SUM_W-1:0] sum;
        sum = (cw[5] ? TNS02_A  : 5'd0)
            + (cw[4] ? TNS02_B  : 5'd0)
            + (cw[3] ? TNS02_C  : 5'd0)
            + (cw[2] ? TNS01_A  : 5'd0)
            + (cw[1] ? TNS01_B  : 5'd0)
            + (cw[0] ? TNS_BIT0 : 5'd0);
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tns_xtalk_check.sv
`default_nettype none
// ============================================================================
// Module      : tns_xtalk_check
// Description : Combinational crosstalk-class detector. Flags any pair of
//               adjacent wires that transition in opposite directions between
//               the previous and the current codeword. Width is a parameter so
//               wider decoders can reuse it.
// Revision    : 1.0  initial release
// ============================================================================
module tns_xtalk_check #(
    parameter int W = 6
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] cur,
    output logic         violation
);

    logic [W-1:0] w_rise;
    logic [W-1:0] w_fall;
    logic [W-2:0] w_pair_bad;

    assign w_rise = ~prev &  cur;
    assign w_fall =  prev & ~cur;

    // Pair i covers wires i and i+1: one rising while the other falls.
    assign w_pair_bad = (w_rise[W-2:0] & w_fall[W-1:1])
                      | (w_fall[W-2:0] & w_rise[W-1:1]);

    assign violation = |w_pair_bad;

endmodule
`default_nettype wire

// File: rtl/tns_decoder_06.sv
`default_nettype none
// ============================================================================
// Module      : tns_decoder_06
// Description : Receive-side stage of the 6-bit TNS link. Two-stage
//               valid/ready pipeline around the weighted-sum decoder, with
//               illegal-codeword and adjacent-wire crosstalk flags and a
//               saturating error counter.
// Revision    : 1.0  initial release
// ============================================================================
module tns_decoder_06
    import tns_decoder_06_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter bit CHK_XTALK = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CW_W-1:0]   codein,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BLEN02-1:0] dataout,
    output logic              err_illegal,
    output logic              err_xtalk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage S1: accepted codeword, the one accepted before it, and whether
    // that earlier codeword is real history (not just the reset value).
    logic [CW_W-1:0]  r_s1_cur;
    logic [CW_W-1:0]  r_s1_prev;
    logic             r_s1_prev_ok;
    logic             r_s1_valid;

    // Set by the first accept after reset; becomes prev_ok for later words.
    logic             r_seen;

    // Stage S2: decoded word and flags.
    dec_word_t        r_s2;
    logic             r_s2_valid;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_adv2;
    logic             w_accept;
    logic             w_deliver;
    logic [SUM_W-1:0] w_sum;
    logic             w_xtalk;
    dec_word_t        w_dec;

    // S2 can take a new word when it is empty or is being drained now.
    assign w_adv2    = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_adv2;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_s2_valid && out_ready;

    assign w_sum = tns_weight_sum(r_s1_cur);

    generate
        if (CHK_XTALK) begin : g_xtalk_on
            logic w_xtalk_raw;

            tns_xtalk_check #(
                .W (CW_W)
            ) u_xtalk (
                .prev      (r_s1_prev),
                .cur       (r_s1_cur),
                .violation (w_xtalk_raw)
            );

            assign w_xtalk = w_xtalk_raw && r_s1_prev_ok;
        end else begin : g_xtalk_off
            assign w_xtalk = 1'b0;
        end
    endgenerate

    // Decode of the word currently held in S1.
    always_comb begin
        w_dec         = '0;
        w_dec.data    = w_sum[BLEN02-1:0];
        w_dec.illegal = (w_sum > DATA_MAX);
        w_dec.xtalk   = w_xtalk;
    end

    // S1 register: capture on accept, shifting the last codeword into prev.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_cur     <= '0;
            r_s1_prev    <= '0;
            r_s1_prev_ok <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_seen       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_cur     <= codein;
                r_s1_prev    <= r_s1_cur;
                r_s1_prev_ok <= r_seen;
                r_seen       <= 1'b1;
                r_s1_valid   <= 1'b1;
            end else if (w_adv2) begin
                r_s1_valid   <= 1'b0;
            end
        end
    end

    // S2 register: load the decode whenever S2 is free to advance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s2       <= '0;
            r_s2_valid <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= w_dec;
            end
        end
    end

    // Error counter: one count per delivered word carrying any flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_deliver && (r_s2.illegal || r_s2.xtalk)
                     && (r_err_cnt != C_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + C_CNT_ONE;
        end
    end

    assign dataout     = r_s2.data;
    assign err_illegal = r_s2.illegal;
    assign err_xtalk   = r_s2.xtalk;
    assign out_valid   = r_s2_valid;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tns_decoder_06.sv
`default_nettype none
// ============================================================================
// Module      : tb_tns_decoder_06
// Description : Self-checking bench for tns_decoder_06 with a queue-based
//               behavioural reference model of the decoder and its flags.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tns_decoder_06;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [5:0] codein;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dataout;
    logic       err_illegal;
    logic       err_xtalk;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] err_cnt;

    always #5 clock = ~clock;

    tns_decoder_06 #(
        .CNT_W     (8),
        .CHK_XTALK (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .codein      (codein),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dataout     (dataout),
        .err_illegal (err_illegal),
        .err_xtalk   (err_xtalk),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_cnt     (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] data;
        logic       ill;
        logic       xt;
    } exp_t;

    // Reference model state: words in flight, error tally, last codeword.
    exp_t     q[$];
    int       m_cnt;
    bit       m_seen;
    bit [5:0] m_prev;

    // Per-cycle observations and model expectations filled by step().
    logic       s_rdy, s_ovalid, s_ill, s_xt;
    logic [3:0] s_data;
    logic [7:0] s_cnt;
    bit         s_rdy_exp, s_acc, s_del;
    int         s_cnt_exp;
    exp_t       s_exp;

    function automatic int ref_sum(bit [5:0] cw);
        int w[6] = '{1, 1, 2, 4, 4, 8};
        int s = 0;
        for (int i = 0; i < 6; i++) s += cw[i] * w[i];
        return s;
    endfunction

    // Direction of each wire is +1/0/-1; opposite neighbours multiply to -1.
    function automatic bit ref_xtalk(bit [5:0] p, bit [5:0] c);
        for (int i = 0; i < 5; i++) begin
            int di = int'(c[i]) - int'(p[i]);
            int dj = int'(c[i+1]) - int'(p[i+1]);
            if (di * dj == -1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: drive at the falling edge, sample, advance the model.
    task automatic step(input bit v, input bit [5:0] cw, input bit ordy);
        @(negedge clock);
        in_valid  = v;
        codein    = cw;
        out_ready = ordy;
        #1;
        s_rdy     = in_ready;
        s_ovalid  = out_valid;
        s_data    = dataout;
        s_ill     = err_illegal;
        s_xt      = err_xtalk;
        s_cnt     = err_cnt;
        s_rdy_exp = (q.size() < 2) || ordy;
        s_cnt_exp = m_cnt;
        s_acc     = v && (in_ready === 1'b1);
        s_del     = (out_valid === 1'b1) && ordy;
        if (s_del) begin
            if (q.size() > 0) s_exp = q.pop_front();
            else              s_exp = '{4'bxxxx, 1'bx, 1'bx};
            if ((s_exp.ill === 1'b1 || s_exp.xt === 1'b1) && m_cnt < 255) m_cnt++;
        end
        if (s_acc) begin
            exp_t e;
            int   s;
            s     = ref_sum(cw);
            e.data = 4'(s % 16);
            e.ill  = (s > 15);
            e.xt   = m_seen && ref_xtalk(m_prev, cw);
            q.push_back(e);
            m_prev = cw;
            m_seen = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        codein   = '0;
        out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        m_cnt  = 0;
        m_seen = 1'b0;
        m_prev = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        checks++;
        if (dataout !== 4'd0 || err_illegal !== 1'b0 || err_xtalk !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: data=%0d ill=%b xt=%b cnt=%0d, want all 0",
                     dataout, err_illegal, err_xtalk, err_cnt);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 6'b101011, 1'b1);
        checks++;
        if (!s_acc) begin
            errors++;
            $display("FAIL basic_accept: in_ready=%b, want 1", s_rdy);
        end
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_n1: out_valid=%b, want 0", s_ovalid);
        end
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_ovalid !== 1'b1 || s_data !== 4'd14 || s_ill !== 1'b0 || s_xt !== 1'b0 || s_cnt !== 8'd0) begin
            errors++;
            $display("FAIL basic_n2: valid=%b data=%0d ill=%b xt=%b cnt=%0d, want 1/14/0/0/0",
                     s_ovalid, s_data, s_ill, s_xt, s_cnt);
        end
    endtask

    task automatic test_illegal();
        step(1'b1, 6'b111000, 1'b1);
        step(1'b0, 6'b000000, 1'b1);
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_ovalid !== 1'b1 || s_data !== 4'd0 || s_ill !== 1'b1 || s_xt !== 1'b0) begin
            errors++;
            $display("FAIL illegal_word: valid=%b data=%0d ill=%b xt=%b, want 1/0/1/0",
                     s_ovalid, s_data, s_ill, s_xt);
        end
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_cnt !== 8'd1) begin
            errors++;
            $display("FAIL illegal_count: err_cnt=%0d, want 1", s_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 6'b010101, 1'b1);
        step(1'b1, 6'b101010, 1'b1);
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_ovalid !== 1'b1 || s_data !== 4'd7 || s_xt !== 1'b0 || s_ill !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: valid=%b data=%0d xt=%b ill=%b, want 1/7/0/0",
                     s_ovalid, s_data, s_xt, s_ill);
        end
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_ovalid !== 1'b1 || s_data !== 4'd13 || s_xt !== 1'b1 || s_ill !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b data=%0d xt=%b ill=%b, want 1/13/1/0",
                     s_ovalid, s_data, s_xt, s_ill);
        end
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_cnt !== 8'd1 || s_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: err_cnt=%0d valid=%b, want 1/0", s_cnt, s_ovalid);
        end
    endtask

    task automatic test_stall();
        int  sent = 0;
        int  got  = 0;
        bit  saw_stall = 1'b0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            step(sent < 8, 6'($urandom_range(0, 63)), !(c >= 3 && c <= 6));
            if (s_acc) sent++;
            if (s_rdy === 1'b0) saw_stall = 1'b1;
            checks++;
            if (s_rdy !== s_rdy_exp) begin
                errors++;
                $display("FAIL stall_in_ready c=%0d: got %b want %b", c, s_rdy, s_rdy_exp);
            end
            if (s_del) begin
                got++;
                checks++;
                if (s_data !== s_exp.data || s_ill !== s_exp.ill || s_xt !== s_exp.xt) begin
                    errors++;
                    $display("FAIL stall_word %0d: got %0d/%b/%b want %0d/%b/%b",
                             got, s_data, s_ill, s_xt, s_exp.data, s_exp.ill, s_exp.xt);
                end
            end
        end
        checks++;
        if (got != 8 || sent != 8 || !saw_stall) begin
            errors++;
            $display("FAIL stall_totals: sent=%0d got=%0d stalled=%b, want 8/8/1", sent, got, saw_stall);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit drain = (c >= 380);
            step(!drain && ($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)),
                 drain || ($urandom_range(0, 2) != 0));
            checks++;
            if (s_rdy !== s_rdy_exp || s_cnt !== s_cnt_exp[7:0]) begin
                errors++;
                $display("FAIL random_ctrl c=%0d: in_ready=%b/%b cnt=%0d/%0d",
                         c, s_rdy, s_rdy_exp, s_cnt, s_cnt_exp);
            end
            if (s_del) begin
                checks++;
                if (s_data !== s_exp.data || s_ill !== s_exp.ill || s_xt !== s_exp.xt) begin
                    errors++;
                    $display("FAIL random_word c=%0d: got %0d/%b/%b want %0d/%b/%b",
                             c, s_data, s_ill, s_xt, s_exp.data, s_exp.ill, s_exp.xt);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: %0d words never delivered, want 0", q.size());
        end
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 304; c++) begin
            step(c < 300, {3'b111, 3'($urandom_range(0, 7))}, 1'b1);
            if (s_del) begin
                checks++;
                if (s_data !== s_exp.data || s_ill !== 1'b1 || s_cnt !== s_cnt_exp[7:0]) begin
                    errors++;
                    $display("FAIL sat_word c=%0d: data=%0d/%0d ill=%b cnt=%0d/%0d",
                             c, s_data, s_exp.data, s_ill, s_cnt, s_cnt_exp);
                end
            end
        end
        checks++;
        if (s_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_count: err_cnt=%0d, want 255", s_cnt);
        end
    endtask

    task automatic test_reset_full();
        step(1'b1, 6'b010101, 1'b0);
        step(1'b1, 6'b010101, 1'b0);
        step(1'b1, 6'b010101, 1'b0);
        checks++;
        if (s_rdy !== 1'b0 || s_ovalid !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: in_ready=%b out_valid=%b, want 0/1", s_rdy, s_ovalid);
        end
        do_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_reset: out_valid=%b err_cnt=%0d in_ready=%b, want 0/0/1",
                     out_valid, err_cnt, in_ready);
        end
        step(1'b1, 6'b101010, 1'b1);
        step(1'b0, 6'b000000, 1'b1);
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_ovalid !== 1'b1 || s_data !== 4'd13 || s_xt !== 1'b0) begin
            errors++;
            $display("FAIL full_history: valid=%b data=%0d xt=%b, want 1/13/0", s_ovalid, s_data, s_xt);
        end
        step(1'b0, 6'b000000, 1'b1);
        checks++;
        if (s_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL full_dropped: out_valid=%b after reset drain, want 0", s_ovalid);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        codein    = '0;
        out_ready = 1'b0;
        m_cnt     = 0;
        m_seen    = 1'b0;
        m_prev    = '0;
        test_reset();
        test_basic();
        test_illegal();
        test_back_to_back();
        test_stall();
        test_random();
        test_saturate();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
